pll_reg_sequencer: RTL
======================

# pll_reg_sequencer

Parametrised serial register programmer for PLL/synthesiser chips with a 3-wire SPI-style interface (DATA, CLK, LE), generalising the fixed three-register, 24-bit loader. On a trigger it captures up to NREG words of WIDTH bits and shifts each enabled word out MSB-first, latching it with an LE pulse. An optional per-register settle delay follows each latch. Sits between the host command/wire-in layer and the synthesiser pins; one instance drives one chip.

## Interface
- NREG, 3: number of register slots; slot 0 is sent first.
- WIDTH, 24: bits per register word (2..32).
- CLKDIV, 4: sclk_o period in clk_i cycles; even, ≥2.
- DELAY_W, 16: width of each per-slot settle delay.
- clk_i  in  1  system clock; all logic on its rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- trig_i  in  1  start request; rising edge detected internally.
- abort_i  in  1  level; cancels an in-progress sequence.
- regs_i  in  NREG*WIDTH  slot k at bits [k*WIDTH +: WIDTH].
- delay_i  in  NREG*DELAY_W  post-latch wait for slot k, in clk_i cycles.
- mask_i  in  NREG  1 = send slot k, 0 = skip it.
- ready_o  out  1  high when idle and able to accept a trigger.
- done_o  out  1  one-cycle pulse when a sequence completes normally.
- sdata_o  out  1  serial data, MSB first.
- sclk_o  out  1  serial clock; idles low.
- le_o  out  1  latch enable; active high.

## Operation
- Reset values: ready_o=1, done_o=0, sdata_o=0, sclk_o=0, le_o=0. The state machine resets to IDLE and the edge detector to 0.
- States: IDLE, LOAD, SHIFT, LATCH, WAIT, DONE.
- IDLE: on trig_i rising edge (trig_i=1 in the current cycle and 0 in the previous one), capture regs_i, delay_i and mask_i into shadow registers, set the slot index to 0 and go to LOAD. ready_o falls on the next cycle.
- LOAD (1 cycle): if the current slot is masked, advance the index. If no enabled slot remains, go to DONE. Otherwise load the shift register with the slot's word and go to SHIFT.
- SHIFT: WIDTH bits. For each bit, sdata_o changes at the start of the low phase; sclk_o is low for CLKDIV/2 cycles, then high for CLKDIV/2 cycles. The chip samples on the sclk_o rising edge. sclk_o returns low after the last bit.
- LATCH: le_o high for CLKDIV cycles with sclk_o low and sdata_o=0. Then go to WAIT.
- WAIT: count down the shadow delay for the slot. A delay of 0 skips WAIT entirely. Then advance the index and go to LOAD.
- DONE (1 cycle): done_o=1, then go to IDLE; ready_o rises on the next cycle.
- Trigger edges outside IDLE are ignored and not queued.
- abort_i=1 in any state other than IDLE/DONE: on the next cycle sclk_o, sdata_o and le_o go to 0 and the FSM goes to IDLE, so a partially shifted word is never latched. ready_o=1 on that same cycle; done_o is not pulsed.
- abort_i and a trigger edge in the same IDLE cycle: the trigger wins.
- Asserting reset_n_i mid-operation forces the reset values immediately (asynchronous); there is no latch pulse.
- All counters are sized from the parameters with clog2 and wrap nowhere. The bit counter runs WIDTH-1 down to 0.

## Timing
- Trigger edge at cycle T: LOAD at T+1, and the first sdata_o bit is valid at T+2.
- Cycles per enabled slot: 1 (LOAD) + WIDTH*CLKDIV + CLKDIV + delay.
- Each masked slot costs 1 LOAD cycle.
- Total from trigger to done_o: sum of the per-slot costs + 1 (DONE).
- All outputs are registered and glitch-free; sclk_o duty is 50%.

## Test plan
- Defaults, mask=3'b111, delays 0, regs 0xABCDEF/0x123456/0x800001: the bench samples on sclk_o rising edges and must decode the three words in order. It must see three le_o pulses of 4 cycles each, and done_o exactly 3*(1+96+4)+1=304 cycles after the trigger edge.
- mask=3'b101: only slots 0 and 2 are shifted (2 LE pulses); done_o arrives at 2*101+1+1=204 cycles.
- delay_i slot0=10, slot1=0: 10 cycles separate LE fall from the next sclk_o activity after slot 0 only; the total grows by 10.
- abort_i pulsed mid-SHIFT of slot 1: le_o never rises for slot 1, outputs are 0 and ready_o=1 the next cycle, and done_o stays 0. A following trigger runs a full sequence.
- trig_i held high for 500 cycles, plus extra edges while busy: exactly one sequence runs. mask=0 gives done_o 2 cycles after the edge with no sclk_o activity.
- reset_n_i low mid-SHIFT: all outputs take their reset values without waiting for a clock edge; after release, the first trigger runs normally.

Source files
------------

// File: rtl/pll_reg_sequencer.sv
// Serial register programmer for 3-wire PLL chips: shifts NREG words MSB-first, LE-latches each, optional settle wait.
// Trigger edge to first data bit is 2 cycles; no backpressure, edges while busy are dropped and abort returns to idle.
module pll_reg_sequencer #(
   parameter int NREG    = 3,
   parameter int WIDTH   = 24,
   parameter int CLKDIV  = 4,
   parameter int DELAY_W = 16
) (
   input  logic                      clk_i,
   input  logic                      reset_n_i,
   input  logic                      trig_i,
   input  logic                      abort_i,
   input  logic [NREG*WIDTH-1:0]     regs_i,
   input  logic [NREG*DELAY_W-1:0]   delay_i,
   input  logic [NREG-1:0]           mask_i,
   output logic                      ready_o,
   output logic                      done_o,
   output logic                      sdata_o,
   output logic                      sclk_o,
   output logic                      le_o
);

   localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;
   localparam int BIT_W = $clog2(WIDTH);
   localparam int PH_W  = $clog2(CLKDIV);
   localparam int HALF  = CLKDIV / 2;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHIFT,
      LATCH,
      WAIT,
      DONE
   } state_t;

   state_t                    state, state_n;
   logic                      trig_q;
   logic                      trig_edge;
   logic [NREG*WIDTH-1:0]     sh_regs, sh_regs_n;
   logic [NREG*DELAY_W-1:0]   sh_delay, sh_delay_n;
   logic [NREG-1:0]           sh_mask, sh_mask_n;
   logic [IDX_W-1:0]          idx, idx_n;
   logic [WIDTH-1:0]          sreg, sreg_n;
   logic [BIT_W-1:0]          bit_cnt, bit_cnt_n;
   logic [PH_W-1:0]           ph, ph_n;
   logic [DELAY_W-1:0]        wcnt, wcnt_n;
   logic                      ready_n, done_n, sdata_n, sclk_n, le_n;
   logic [WIDTH-1:0]          cur_word;
   logic [DELAY_W-1:0]        cur_delay;
   logic                      later_any;

   assign trig_edge = trig_i & ~trig_q;
   assign cur_word  = sh_regs[int'(idx)*WIDTH +: WIDTH];
   assign cur_delay = sh_delay[int'(idx)*DELAY_W +: DELAY_W];

   // Any enabled slot after the current one decides between next LOAD and DONE.
   always_comb begin
      later_any = 1'b0;
      for (int k = 0; k < NREG; k++) begin
         if (k > int'(idx) && sh_mask[k]) later_any = 1'b1;
      end
   end

   always_comb begin
      state_n    = state;
      sh_regs_n  = sh_regs;
      sh_delay_n = sh_delay;
      sh_mask_n  = sh_mask;
      idx_n      = idx;
      sreg_n     = sreg;
      bit_cnt_n  = bit_cnt;
      ph_n       = ph;
      wcnt_n     = wcnt;
      ready_n    = ready_o;
      done_n     = 1'b0;
      sdata_n    = sdata_o;
      sclk_n     = sclk_o;
      le_n       = le_o;

      case (state)
         IDLE: begin
            if (trig_edge) begin
               sh_regs_n  = regs_i;
               sh_delay_n = delay_i;
               sh_mask_n  = mask_i;
               idx_n      = '0;
               ready_n    = 1'b0;
               state_n    = LOAD;
            end
         end
         LOAD: begin
            if (sh_mask[idx]) begin
               sreg_n    = cur_word;
               sdata_n   = cur_word[WIDTH-1];
               sclk_n    = 1'b0;
               bit_cnt_n = BIT_W'(WIDTH - 1);
               ph_n      = '0;
               state_n   = SHIFT;
            end else if (later_any) begin
               idx_n = idx + IDX_W'(1);
            end else begin
               done_n  = 1'b1;
               state_n = DONE;
            end
         end
         SHIFT: begin
            if (ph == PH_W'(HALF - 1)) begin
               sclk_n = 1'b1;
               ph_n   = ph + PH_W'(1);
            end else if (ph == PH_W'(CLKDIV - 1)) begin
               ph_n   = '0;
               sclk_n = 1'b0;
               if (bit_cnt == '0) begin
                  sdata_n = 1'b0;
                  le_n    = 1'b1;
                  state_n = LATCH;
               end else begin
                  // Rotate keeps every bit in use; the bit after the MSB sits at WIDTH-2.
                  bit_cnt_n = bit_cnt - BIT_W'(1);
                  sreg_n    = {sreg[WIDTH-2:0], sreg[WIDTH-1]};
                  sdata_n   = sreg[WIDTH-2];
               end
            end else begin
               ph_n = ph + PH_W'(1);
            end
         end
         LATCH: begin
            if (ph == PH_W'(CLKDIV - 1)) begin
               ph_n = '0;
               le_n = 1'b0;
               if (cur_delay != '0) begin
                  wcnt_n  = cur_delay;
                  state_n = WAIT;
               end else if (later_any) begin
                  idx_n   = idx + IDX_W'(1);
                  state_n = LOAD;
               end else begin
                  done_n  = 1'b1;
                  state_n = DONE;
               end
            end else begin
               ph_n = ph + PH_W'(1);
            end
         end
         WAIT: begin
            if (wcnt == DELAY_W'(1)) begin
               if (later_any) begin
                  idx_n   = idx + IDX_W'(1);
                  state_n = LOAD;
               end else begin
                  done_n  = 1'b1;
                  state_n = DONE;
               end
            end else begin
               wcnt_n = wcnt - DELAY_W'(1);
            end
         end
         DONE: begin
            ready_n = 1'b1;
            state_n = IDLE;
         end
         default: begin
            ready_n = 1'b1;
            state_n = IDLE;
         end
      endcase

      // Abort drops the pins straight to idle so a half-shifted word is never latched.
      if (abort_i && state != IDLE && state != DONE) begin
         state_n = IDLE;
         sclk_n  = 1'b0;
         sdata_n = 1'b0;
         le_n    = 1'b0;
         done_n  = 1'b0;
         ready_n = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state    <= IDLE;
         trig_q   <= 1'b0;
         sh_regs  <= '0;
         sh_delay <= '0;
         sh_mask  <= '0;
         idx      <= '0;
         sreg     <= '0;
         bit_cnt  <= '0;
         ph       <= '0;
         wcnt     <= '0;
         ready_o  <= 1'b1;
         done_o   <= 1'b0;
         sdata_o  <= 1'b0;
         sclk_o   <= 1'b0;
         le_o     <= 1'b0;
      end else begin
         state    <= state_n;
         trig_q   <= trig_i;
         sh_regs  <= sh_regs_n;
         sh_delay <= sh_delay_n;
         sh_mask  <= sh_mask_n;
         idx      <= idx_n;
         sreg     <= sreg_n;
         bit_cnt  <= bit_cnt_n;
         ph       <= ph_n;
         wcnt     <= wcnt_n;
         ready_o  <= ready_n;
         done_o   <= done_n;
         sdata_o  <= sdata_n;
         sclk_o   <= sclk_n;
         le_o     <= le_n;
      end
   end

endmodule
